// File: rtl/sym9_pkg.sv
// Shared definitions for the 9symml evaluator and its round-robin sharing arbiter.
// Function width, the popcount window that yields a 1, FSM states and popcount helper.
package sym9_pkg;

    localparam int SYM9_W  = 9;
    localparam int SYM9_LO = 3;
    localparam int SYM9_HI = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    function automatic logic [3:0] popcount9(input logic [SYM9_W-1:0] value);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < SYM9_W; i++) begin
            sum = sum + {3'd0, value[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/sym9_eval.sv
// Combinational 9symml evaluator.
// The output is 1 when the operand's popcount lies inside the SYM9_LO..SYM9_HI window.
module sym9_eval
    import sym9_pkg::*;
(
    input  logic [SYM9_W-1:0] i_operand,
    output logic              o_resBit,
    output logic [3:0]        o_weight
);

    logic [3:0] w_weight;

    assign w_weight = popcount9(i_operand);
    assign o_weight = w_weight;
    assign o_resBit = (w_weight >= 4'(SYM9_LO)) && (w_weight <= 4'(SYM9_HI));

endmodule

// File: rtl/sym9_share_arbiter.sv
// Round-robin arbiter sharing one sym9_eval between N_REQ valid/ready requesters.
// Each result is registered together with the requester ID and is held until the consumer accepts it.
module sym9_share_arbiter
    import sym9_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int EVAL_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [SYM9_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_bit,
    output logic [3:0]                res_weight,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy,
    output logic [CNT_W-1:0]          eval_cnt
);

    localparam int TMR_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;

    stateT              r_state;
    stateT              w_nextState;
    logic [ID_W-1:0]    r_rrPtr;
    logic [SYM9_W-1:0]  r_operand;
    logic [ID_W-1:0]    r_reqId;
    logic [TMR_W-1:0]   r_timer;
    logic               r_resBit;
    logic [3:0]         r_resWeight;
    logic [ID_W-1:0]    r_resId;
    logic [CNT_W-1:0]   r_evalCnt;

    logic               w_grantFound;
    logic [ID_W-1:0]    w_grantIdx;
    logic [ID_W:0]      w_candIdx;
    logic [N_REQ-1:0]   w_grantOneHot;
    logic [SYM9_W-1:0]  w_grantData;
    logic               w_evalBit;
    logic [3:0]         w_evalWeight;

    // Search upward from the last winner so every waiting requester is reached within N_REQ grants.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_candIdx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_candIdx = {1'b0, r_rrPtr} + (ID_W+1)'(k);
            if (w_candIdx >= (ID_W+1)'(N_REQ)) begin
                w_candIdx = w_candIdx - (ID_W+1)'(N_REQ);
            end
            if (!w_grantFound && req_valid[w_candIdx[ID_W-1:0]]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_candIdx[ID_W-1:0];
            end
        end
    end

    assign w_grantOneHot = w_grantFound ? (N_REQ'(1) << w_grantIdx) : '0;
    assign w_grantData   = req_data[SYM9_W*int'(w_grantIdx) +: SYM9_W];

    sym9_eval u_eval (
        .i_operand (r_operand),
        .o_resBit  (w_evalBit),
        .o_weight  (w_evalWeight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grantFound)    w_nextState = BUSY;
            BUSY:    if (r_timer == '0)   w_nextState = DONE;
            DONE:    if (res_ready)       w_nextState = IDLE;
            default:                      w_nextState = IDLE;
        endcase
    end

    // req_ready is masked by rst_n so a held request cannot see a grant while reset is asserted.
    always_comb begin
        req_ready = '0;
        res_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            IDLE: req_ready = rst_n ? w_grantOneHot : '0;
            BUSY: busy      = 1'b1;
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr     <= ID_W'(N_REQ - 1);
            r_operand   <= '0;
            r_reqId     <= '0;
            r_timer     <= '0;
            r_resBit    <= 1'b0;
            r_resWeight <= 4'd0;
            r_resId     <= '0;
            r_evalCnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantFound) begin
                        r_operand <= w_grantData;
                        r_reqId   <= w_grantIdx;
                        r_rrPtr   <= w_grantIdx;
                        r_timer   <= TMR_W'(EVAL_LAT - 1);
                    end
                end
                BUSY: begin
                    if (r_timer == '0) begin
                        r_resBit    <= w_evalBit;
                        r_resWeight <= w_evalWeight;
                        r_resId     <= r_reqId;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_evalCnt <= r_evalCnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_bit    = r_resBit;
    assign res_weight = r_resWeight;
    assign res_id     = r_resId;
    assign eval_cnt   = r_evalCnt;

endmodule
